// File: rtl/ucode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ucode_pkg                                                    |
// | Description : Opcode constants, uop entry type and opcode -> microcode map |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package ucode_pkg;

    localparam logic [7:0] c_uaddr_nop    = 8'hFF;

    localparam logic [7:0] c_op_alu_first = 8'h01;
    localparam logic [7:0] c_op_alu_last  = 8'h07;
    localparam logic [7:0] c_op_div       = 8'h09;
    localparam logic [7:0] c_op_alui_lo   = 8'h0A;
    localparam logic [7:0] c_op_mul       = 8'h11;
    localparam logic [7:0] c_op_alui_hi   = 8'h12;
    localparam logic [7:0] c_op_mem_first = 8'h21;
    localparam logic [7:0] c_op_mem_last  = 8'h27;
    localparam logic [7:0] c_op_jmp       = 8'h40;
    localparam logic [7:0] c_op_call      = 8'h60;
    localparam logic [7:0] c_op_mcall     = 8'h80;
    localparam logic [7:0] c_op_ret       = 8'h81;
    localparam logic [7:0] c_op_sys       = 8'h91;
    localparam logic [7:0] c_op_nop       = 8'hFF;

    typedef struct packed {
        logic [7:0] uaddr;
        logic [2:0] ucnt;
        logic       illegal;
    } uop_entry_t;

    function automatic uop_entry_t mk_entry(input logic [7:0] uaddr, input logic [2:0] ucnt);
        uop_entry_t e;
        e.uaddr   = uaddr;
        e.ucnt    = ucnt;
        e.illegal = 1'b0;
        return e;
    endfunction

    // Anything not listed falls to the NOP address; only 0xFF is a legal NOP.
    function automatic uop_entry_t ucode_lookup(input logic [7:0] key);
        uop_entry_t e;
        e.uaddr   = c_uaddr_nop;
        e.ucnt    = 3'd0;
        e.illegal = (key != c_op_nop);
        case (key) inside
            [c_op_alu_first:c_op_alu_last]: e = mk_entry(key - c_op_alu_first, 3'd0);
            c_op_mul:                       e = mk_entry(8'h07, 3'd2);
            c_op_div:                       e = mk_entry(8'h0A, 3'd2);
            c_op_alui_hi + 8'd0:            e = mk_entry(8'h0D, 3'd2);
            c_op_alui_lo + 8'd0:            e = mk_entry(8'h10, 3'd2);
            c_op_alui_hi + 8'd1:            e = mk_entry(8'h13, 3'd2);
            c_op_alui_lo + 8'd1:            e = mk_entry(8'h16, 3'd2);
            c_op_alui_hi + 8'd2:            e = mk_entry(8'h19, 3'd2);
            c_op_alui_lo + 8'd2:            e = mk_entry(8'h1C, 3'd2);
            c_op_alui_hi + 8'd3:            e = mk_entry(8'h1F, 3'd2);
            c_op_alui_lo + 8'd3:            e = mk_entry(8'h22, 3'd2);
            c_op_alui_hi + 8'd4:            e = mk_entry(8'h25, 3'd2);
            c_op_alui_lo + 8'd4:            e = mk_entry(8'h28, 3'd2);
            c_op_alui_hi + 8'd5:            e = mk_entry(8'h2B, 3'd2);
            c_op_alui_lo + 8'd5:            e = mk_entry(8'h2E, 3'd2);
            [c_op_mem_first:c_op_mem_last]: e = mk_entry(key + 8'h10, 3'd0);
            c_op_jmp:                       e = mk_entry(8'h38, 3'd0);
            c_op_call:                      e = mk_entry(8'h39, 3'd0);
            c_op_mcall:                     e = mk_entry(8'h3A, 3'd4);
            c_op_ret:                       e = mk_entry(8'h3F, 3'd1);
            c_op_sys:                       e = mk_entry(8'h41, 3'd1);
            default:                        ;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucode_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ucode_map                                                    |
// | Description : Combinational opcode key -> microcode entry lookup           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ucode_map
    import ucode_pkg::*;
(
    input  logic [7:0] i_key,
    output uop_entry_t o_entry
);

    assign o_entry = ucode_lookup(i_key);

endmodule
`default_nettype wire

// File: rtl/ucode_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ucode_decode_stage                                           |
// | Description : Microcode decode stage with registered output FIFO.          |
// |               Define UCODE_DECODE_ILLEGAL_TRAP_EN for illegal-op trapping. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ucode_decode_stage
    import ucode_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 8,
    parameter int UADDR_W = 8,
    parameter int UCNT_W  = 3,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc_nt,
    input  logic [PC_W-1:0]    in_br_pc,
    input  logic               in_pred,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [UADDR_W-1:0] out_uaddr,
    output logic [UCNT_W-1:0]  out_ucnt,
    output logic [2:0]         out_opcode,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [2:0]         out_rd,
    output logic [PC_W-1:0]    out_pc_nt,
    output logic [PC_W-1:0]    out_br_pc,
    output logic               out_pred,
    output logic               out_illegal
`ifdef UCODE_DECODE_ILLEGAL_TRAP_EN
    ,
    output logic [7:0]         illegal_cnt
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INSTR_W + UADDR_W + UCNT_W + 2 * PC_W + 2;

    localparam logic [1:0] c_st_empty   = 2'd0;
    localparam logic [1:0] c_st_partial = 2'd1;
    localparam logic [1:0] c_st_full    = 2'd2;

`ifdef UCODE_DECODE_ILLEGAL_TRAP_EN
    localparam logic c_trap_en = 1'b1;
`else
    localparam logic c_trap_en = 1'b0;
`endif

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic               ready_en_q, ready_en_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    uop_entry_t         w_map;
    logic [UADDR_W-1:0] w_uaddr;
    logic [UCNT_W-1:0]  w_ucnt;
    logic               w_illegal;
    logic [ENTRY_W-1:0] w_entry;
    logic               w_out_valid, w_push, w_pop;

    logic [INSTR_W-1:0] w_h_instr;
    logic [UADDR_W-1:0] w_h_uaddr;
    logic [UCNT_W-1:0]  w_h_ucnt;
    logic [PC_W-1:0]    w_h_pc_nt, w_h_br_pc;
    logic               w_h_pred, w_h_illegal;

    ucode_map u_map (
        .i_key   (in_instr[INSTR_W-1 -: 8]),
        .o_entry (w_map)
    );

    // Narrow address buses keep the table LSBs; wide ones keep NOP as all-ones.
    generate
        if (UADDR_W <= 8) begin : g_uaddr_trunc
            assign w_uaddr = w_map.uaddr[UADDR_W-1:0];
        end else begin : g_uaddr_ext
            assign w_uaddr = (w_map.uaddr == c_uaddr_nop) ? '1 : UADDR_W'(w_map.uaddr);
        end
        if (UCNT_W >= 3) begin : g_ucnt_ext
            assign w_ucnt = UCNT_W'(w_map.ucnt);
        end else begin : g_ucnt_sat
            assign w_ucnt = (w_map.ucnt > 3'((1 << UCNT_W) - 1)) ? '1 : w_map.ucnt[UCNT_W-1:0];
        end
    endgenerate

    assign w_illegal   = w_map.illegal & c_trap_en;
    assign w_entry     = {in_instr, w_uaddr, w_ucnt, in_pc_nt, in_br_pc, in_pred, w_illegal};

    assign w_out_valid = (state_q != c_st_empty);
    assign w_pop       = w_out_valid & out_ready;
    assign in_ready    = ready_en_q & ((count_q < CNT_W'(DEPTH)) | w_pop);
    assign w_push      = in_valid & in_ready;
    assign ready_en_d  = 1'b1;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            state_d  = c_st_empty;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = w_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: ;
            endcase
            case (state_q)
                c_st_empty: begin
                    if (w_push) state_d = c_st_partial;
                end
                c_st_partial: begin
                    if (w_push && !w_pop && count_q == CNT_W'(DEPTH - 1)) state_d = c_st_full;
                    else if (w_pop && !w_push && count_q == CNT_W'(1))    state_d = c_st_empty;
                end
                c_st_full: begin
                    if (w_pop && !w_push) state_d = c_st_partial;
                end
                default: state_d = c_st_empty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_st_empty;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            ready_en_q <= ready_en_d;
        end
    end

    // Payload storage needs no reset: every output is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef UCODE_DECODE_ILLEGAL_TRAP_EN
    logic [7:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (w_push && !flush && w_map.illegal && illegal_cnt_q != 8'hFF) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_cnt_q <= 8'd0;
        else     illegal_cnt_q <= illegal_cnt_d;
    end

    assign illegal_cnt = illegal_cnt_q;
`endif

    assign {w_h_instr, w_h_uaddr, w_h_ucnt, w_h_pc_nt, w_h_br_pc, w_h_pred, w_h_illegal} = mem_q[rd_ptr_q];

    assign out_valid   = w_out_valid;
    assign out_instr   = w_out_valid ? w_h_instr   : '0;
    assign out_uaddr   = w_out_valid ? w_h_uaddr   : '1;
    assign out_ucnt    = w_out_valid ? w_h_ucnt    : '0;
    assign out_pc_nt   = w_out_valid ? w_h_pc_nt   : '0;
    assign out_br_pc   = w_out_valid ? w_h_br_pc   : '0;
    assign out_pred    = w_out_valid & w_h_pred;
    assign out_illegal = w_out_valid & w_h_illegal;
    assign out_opcode  = out_instr[2:0];
    assign out_rs1     = out_instr[7:3];
    assign out_rs2     = out_instr[12:8];
    assign out_rd      = out_instr[15:13];

endmodule
`default_nettype wire

// File: tb/tb_ucode_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ucode_decode_stage                                        |
// | Description : Scoreboard bench with a queue-based reference model          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ucode_decode_stage;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 8;
    localparam int UADDR_W = 8;
    localparam int UCNT_W  = 3;
    localparam int DEPTH   = 2;
`ifdef UCODE_DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
    logic [7:0] illegal_cnt;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_pred = 1'b0;
    logic in_ready, out_valid, out_pred, out_illegal;
    logic [INSTR_W-1:0] in_instr = '0, out_instr;
    logic [PC_W-1:0]    in_pc_nt = '0, in_br_pc = '0, out_pc_nt, out_br_pc;
    logic [UADDR_W-1:0] out_uaddr;
    logic [UCNT_W-1:0]  out_ucnt;
    logic [2:0]         out_opcode, out_rd;
    logic [4:0]         out_rs1, out_rs2;

    always #5 clk = ~clk;

    ucode_decode_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W), .UADDR_W(UADDR_W),
                         .UCNT_W(UCNT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc_nt(in_pc_nt), .in_br_pc(in_br_pc), .in_pred(in_pred),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_uaddr(out_uaddr), .out_ucnt(out_ucnt), .out_opcode(out_opcode),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_pc_nt(out_pc_nt),
        .out_br_pc(out_br_pc), .out_pred(out_pred), .out_illegal(out_illegal)
`ifdef UCODE_DECODE_ILLEGAL_TRAP_EN
        , .illegal_cnt(illegal_cnt)
`endif
    );

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [7:0]         uaddr;
        logic [2:0]         ucnt;
        logic [PC_W-1:0]    pc_nt, br_pc;
        logic               pred, ill;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop, e_new;
    int   checks = 0, errors = 0, ill_model = 0, since_rst = 0;
    bit   exp_rdy;
    logic [7:0] keys [17] = '{8'h01, 8'h07, 8'h11, 8'h09, 8'h12, 8'h0A, 8'h17, 8'h0F, 8'h21,
                              8'h27, 8'h40, 8'h60, 8'h80, 8'h81, 8'h91, 8'hFF, 8'h55};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference table written from the opcode map's arithmetic description.
    function automatic void ref_map(input logic [7:0] k, output logic [7:0] a,
                                    output logic [2:0] c, output bit ill);
        int ki = int'(k);
        a = 8'hFF; c = 3'd0; ill = (ki != 'hFF);
        if (ki >= 'h01 && ki <= 'h07)      begin a = 8'(ki - 1);               ill = 0; end
        else if (ki == 'h11)               begin a = 8'h07; c = 3'd2;          ill = 0; end
        else if (ki == 'h09)               begin a = 8'h0A; c = 3'd2;          ill = 0; end
        else if (ki >= 'h12 && ki <= 'h17) begin a = 8'('h0D + 6 * (ki - 'h12)); c = 3'd2; ill = 0; end
        else if (ki >= 'h0A && ki <= 'h0F) begin a = 8'('h10 + 6 * (ki - 'h0A)); c = 3'd2; ill = 0; end
        else if (ki >= 'h21 && ki <= 'h27) begin a = 8'(ki + 'h10);            ill = 0; end
        else if (ki == 'h40)               begin a = 8'h38;                    ill = 0; end
        else if (ki == 'h60)               begin a = 8'h39;                    ill = 0; end
        else if (ki == 'h80)               begin a = 8'h3A; c = 3'd4;          ill = 0; end
        else if (ki == 'h81)               begin a = 8'h3F; c = 3'd1;          ill = 0; end
        else if (ki == 'h91)               begin a = 8'h41; c = 3'd1;          ill = 0; end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)            since_rst <= 0;
        else if (since_rst < 3) since_rst <= since_rst + 1;
    end

    // Monitor and scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_uaddr", out_uaddr, 8'hFF);
            chk("rst_out_ucnt", out_ucnt, 0);
            chk("rst_out_instr", out_instr, 0);
            sb.delete();
            ill_model = 0;
        end else begin
            exp_rdy = (since_rst >= 1) && (sb.size() < DEPTH || (sb.size() > 0 && out_ready));
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, sb.size() > 0);
`ifdef UCODE_DECODE_ILLEGAL_TRAP_EN
            chk("illegal_cnt", illegal_cnt, ill_model);
`endif
            if (sb.size() == 0) begin
                chk("idle_uaddr", out_uaddr, 8'hFF);
                chk("idle_ucnt", out_ucnt, 0);
            end else if (out_ready) begin
                e_pop = sb.pop_front();
                chk("instr", out_instr, e_pop.instr);
                chk("uaddr", out_uaddr, e_pop.uaddr);
                chk("ucnt", out_ucnt, e_pop.ucnt);
                chk("opcode", out_opcode, e_pop.instr[2:0]);
                chk("rs1", out_rs1, e_pop.instr[7:3]);
                chk("rs2", out_rs2, e_pop.instr[12:8]);
                chk("rd", out_rd, e_pop.instr[15:13]);
                chk("pc_nt", out_pc_nt, e_pop.pc_nt);
                chk("br_pc", out_br_pc, e_pop.br_pc);
                chk("pred", out_pred, e_pop.pred);
                chk("illegal", out_illegal, e_pop.ill && TRAP);
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && exp_rdy) begin
                e_new.instr = in_instr;
                e_new.pc_nt = in_pc_nt;
                e_new.br_pc = in_br_pc;
                e_new.pred  = in_pred;
                ref_map(in_instr[INSTR_W-1 -: 8], e_new.uaddr, e_new.ucnt, e_new.ill);
                sb.push_back(e_new);
                if (e_new.ill && ill_model < 255) ill_model++;
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] key, input bit ordy, input bit fl, output bit acc);
        in_valid  = v;
        in_instr  = {key, 24'($urandom)};
        in_pc_nt  = PC_W'($urandom);
        in_br_pc  = PC_W'($urandom);
        in_pred   = 1'($urandom);
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = v && in_ready && !fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        logic [7:0] key;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("ready_first_cycle", in_ready, 0);
        cyc(0, 8'h00, 0, 0, acc);
        chk("ready_second_cycle", in_ready, 1);

        cyc(1, 8'h11, 1, 0, acc);
        chk("s1_valid", out_valid, 1);
        chk("s1_uaddr", out_uaddr, 8'h07);
        chk("s1_ucnt", out_ucnt, 2);
        cyc(0, 8'h00, 1, 0, acc);

        cyc(1, 8'h80, 0, 0, acc);
        cyc(1, 8'h81, 0, 0, acc);
        chk("s2_full_ready", in_ready, 0);
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) cyc(1, 8'h91, 1, 0, acc);
        chk("s2_accept_bound", acc, 1);
        chk("s2_head_81", out_uaddr, 8'h3F);
        cyc(0, 8'h00, 1, 0, acc);
        chk("s2_head_91", out_uaddr, 8'h41);
        repeat (2) cyc(0, 8'h00, 1, 0, acc);

        cyc(1, 8'h01, 0, 0, acc);
        cyc(1, 8'h02, 0, 0, acc);
        cyc(1, 8'h03, 1, 0, acc);
        chk("s3_accept", acc, 1);
        chk("s3_head", out_uaddr, 8'h01);
        cyc(0, 8'h00, 0, 0, acc);
        chk("s3_still_full", in_ready, 0);
        repeat (3) cyc(0, 8'h00, 1, 0, acc);

        cyc(1, 8'h21, 0, 0, acc);
        cyc(1, 8'h22, 0, 0, acc);
        cyc(1, 8'h40, 1, 1, acc);
        chk("s4_valid", out_valid, 0);
        chk("s4_uaddr", out_uaddr, 8'hFF);
        cyc(0, 8'h00, 1, 0, acc);
        chk("s4_dropped", out_valid, 0);

        cyc(1, 8'h55, 1, 0, acc);
        chk("s5_uaddr", out_uaddr, 8'hFF);
        chk("s5_ucnt", out_ucnt, 0);
        chk("s5_illegal", out_illegal, TRAP);
`ifdef UCODE_DECODE_ILLEGAL_TRAP_EN
        chk("s5_illegal_cnt", illegal_cnt, 1);
`endif
        cyc(0, 8'h00, 1, 0, acc);

        for (int i = 0; i < 400; i++) begin
            key = ($urandom_range(0, 3) != 0) ? keys[$urandom_range(0, 16)] : 8'($urandom);
            cyc($urandom_range(0, 3) != 0, key, $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0, acc);
        end

        repeat (3) cyc(0, 8'h00, 1, 0, acc);
        cyc(1, 8'h60, 0, 0, acc);
        cyc(1, 8'h40, 0, 0, acc);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("s6_valid", out_valid, 0);
        chk("s6_ready", in_ready, 0);
        chk("s6_uaddr", out_uaddr, 8'hFF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("s6_ready_release", in_ready, 0);
        @(posedge clk);
        #1;
        chk("s6_ready_after", in_ready, 1);
        chk("s6_empty", out_valid, 0);
        cyc(0, 8'h00, 1, 0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
